lsu_handshake: RTL and testbench
================================

# lsu_handshake

Multi-cycle load/store unit for the single-cycle core. It sits between the execute stage and data memory. It replaces the fixed one-shot memory stall with a req/ack handshake to memory, and it holds the core stalled until the access completes, faults or is flushed. It generates byte enables, lane-aligns store data, extracts and sign/zero-extends load data, and flags misaligned accesses before any bus request is issued.

## Interface
- N, 64: datapath width; legal values 32 or 64. LANES = N/8, MAXW = log2(LANES).
- TIMEOUT, 16: maximum cycles to wait for dm_ack before flagging a fault; 0 disables the timeout.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op_read  in  1  load request from execute, level, held while stall=1.
- op_write  in  1  store request; op_read=op_write=1 is treated as a store.
- op_signed  in  1  1 = sign-extend load result, 0 = zero-extend.
- op_width  in  2  access size 2^op_width bytes (0 B, 1 H, 2 W, 3 D).
- op_addr  in  N  byte address.
- op_wdata  in  N  store data, right-justified.
- flush  in  1  trap/redirect; aborts the access in flight.
- stall  out  1  freeze PC/regfile write.
- rd_data  out  N  extended load result.
- rd_valid  out  1  rd_data valid, one-cycle pulse.
- exc_misalign  out  1  misaligned or illegal-width access, combinational.
- exc_fault  out  1  bus timeout, one-cycle pulse.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  write strobe, registered.
- dm_addr  out  N  op_addr with the low MAXW bits cleared, registered.
- dm_be  out  LANES  byte enables, registered.
- dm_wdata  out  N  lane-shifted store data, registered.
- dm_rdata  in  N  memory read data, sampled on dm_ack.
- dm_ack  in  1  memory completion, valid only while dm_req=1.
- stall_cnt  out  32  present only with LSU_PERF_CNT_EN.

## Operation
- States are IDLE, WAIT and DONE.
- IDLE, no request:
  - Outputs are quiet.
- IDLE, request with an illegal access:
  - An access is illegal when op_width > MAXW or op_addr[op_width-1:0] != 0.
  - exc_misalign=1 combinationally, stall=0, no bus request, state stays IDLE.
- IDLE, request with a legal access, flush=0:
  - Register dm_addr, dm_we, dm_be and dm_wdata.
  - dm_be = ((1<<2^op_width)-1) << off, where off = op_addr[MAXW-1:0].
  - dm_wdata = op_wdata << 8*off.
  - Set dm_req=1 and go to WAIT.
  - stall=1 combinationally in the accept cycle.
- WAIT:
  - stall=1 and dm_req=1.
  - dm_ack: capture (dm_rdata >> 8*off), masked to the access width and extended per op_signed. Go to DONE with rd_valid=1 for loads, rd_valid=0 for stores.
  - TIMEOUT expires without dm_ack: go to DONE with exc_fault=1 and rd_data=0.
- DONE:
  - stall=0 and dm_req=0, so the core retires the instruction this cycle.
  - Next state is IDLE unconditionally. The held request is not re-accepted.
- flush in WAIT or DONE:
  - Go to IDLE next cycle; dm_req, rd_valid and exc_fault are forced 0.
  - flush and dm_ack in the same cycle: flush wins and the data is discarded. A store may already have committed in memory.
  - flush in IDLE blocks acceptance of a request.
- Wait counter: TIMEOUT-sized. It clears on entering WAIT and saturates.

## Timing
- Reset value of every output is 0; state is IDLE and the counter is 0.
- Reset mid-access aborts immediately and dm_req drops asynchronously.
- Minimum latency, with dm_ack on the first WAIT cycle: accept (stall) → WAIT (stall) → DONE (no stall), so 2 stall cycles.
- General stall length is 2 + k cycles, where dm_ack arrives k cycles after the first WAIT cycle.
- Timeout: exc_fault asserts in DONE after exactly TIMEOUT WAIT cycles without ack.
- rd_data holds its value until the next captured load; rd_valid is a pulse in DONE only.
- Back-to-back requests: the next request can be accepted in the IDLE cycle immediately after DONE.

## Configuration
- LSU_PERF_CNT_EN defined:
  - stall_cnt port exists; a 32-bit counter increments on every cycle with stall=1.
  - It wraps at 2^32 and clears on reset only.
- Undefined:
  - The port and the counter are absent.
  - All other behaviour is identical.

## Test plan
- N=64 signed byte load at addr 0x1003 (op_width=0, op_signed=1): dm_be=0x08, dm_addr=0x1000. dm_rdata=0x0000_0000_8000_0000 with ack in the first WAIT cycle → rd_data=0xFFFF_FFFF_FFFF_FF80, 2 stall cycles.
- Half store at 0x2006, op_wdata=0xBEEF: dm_be=0xC0, dm_wdata=0xBEEF_0000_0000_0000, dm_we=1. Ack after 3 WAIT cycles → stall lasts 5 cycles, rd_valid=0.
- Word load at 0x3002: exc_misalign=1 in the same cycle, dm_req stays 0, stall=0. N=32 with op_width=3 at any address → exc_misalign=1.
- TIMEOUT=4, ack held low: exc_fault pulses once after 4 WAIT cycles, dm_req drops in DONE, rd_data=0.
- flush asserted in WAIT together with dm_ack: next state IDLE, rd_valid=0, no exc_fault. Reset asserted mid-WAIT: dm_req=0 asynchronously.
- With LSU_PERF_CNT_EN: three 2-stall loads → stall_cnt=6. Preload the counter to 0xFFFF_FFFF via force, one stall cycle → 0.

Source files
------------

// File: rtl/lsu_handshake.sv
// Load/store unit: req/ack memory handshake, lane alignment, load extension.
// Optional LSU_PERF_CNT_EN adds a 32-bit stall cycle counter (stall_cnt).
module lsu_handshake #(
   parameter int N       = 64,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               op_read,
   input  logic               op_write,
   input  logic               op_signed,
   input  logic [1:0]         op_width,
   input  logic [N-1:0]       op_addr,
   input  logic [N-1:0]       op_wdata,
   input  logic               flush,
   output logic               stall,
   output logic [N-1:0]       rd_data,
   output logic               rd_valid,
   output logic               exc_misalign,
   output logic               exc_fault,
   output logic               dm_req,
   output logic               dm_we,
   output logic [N-1:0]       dm_addr,
   output logic [N/8-1:0]     dm_be,
   output logic [N-1:0]       dm_wdata,
   input  logic [N-1:0]       dm_rdata,
   input  logic               dm_ack
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [31:0]        stall_cnt
`endif
);

   localparam int LANES = N / 8;
   localparam int MAXW  = $clog2(LANES);
   localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t            state, state_nx;
   logic              req, illegal, accept, tmo;
   logic [2:0]        amask;
   logic [MAXW-1:0]   off, off_q;
   logic [1:0]        width_q;
   logic              signed_q;
   logic [CW-1:0]     cnt;
   logic              req_q, rd_valid_q, fault_q;
   logic [LANES-1:0]  be_base;
   logic [N-1:0]      sh, msk, ext;
   logic              sb;

   assign req     = op_read | op_write;
   assign off     = op_addr[MAXW-1:0];
   assign amask   = 3'((4'd1 << op_width) - 4'd1);
   assign illegal = (op_width > 2'(MAXW)) | (|(op_addr[2:0] & amask));
   assign accept  = (state == IDLE) & req & ~illegal & ~flush;
   assign tmo     = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1)) && !dm_ack;

   assign stall        = accept | (state == WAIT);
   assign exc_misalign = (state == IDLE) & req & illegal;
   assign dm_req       = req_q & ~flush;
   assign rd_valid     = rd_valid_q & ~flush;
   assign exc_fault    = fault_q & ~flush;

   always_comb begin
      be_base = '1;
      case (op_width)
         2'd0:    be_base = LANES'(1);
         2'd1:    be_base = LANES'(3);
         2'd2:    be_base = LANES'(15);
         default: be_base = '1;
      endcase
   end

   // Load result: shift lane down, mask to width, fill upper bits.
   always_comb begin
      sh  = dm_rdata >> {off_q, 3'b000};
      msk = '1;
      sb  = 1'b0;
      case (width_q)
         2'd0: begin msk = N'(8'hFF);         sb = sh[7];  end
         2'd1: begin msk = N'(16'hFFFF);      sb = sh[15]; end
         2'd2: begin msk = N'(32'hFFFF_FFFF); sb = sh[31]; end
         default: begin msk = '1;             sb = 1'b0;   end
      endcase
      ext = (sh & msk) | ({N{signed_q & sb}} & ~msk);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = WAIT;
         WAIT: begin
            if (flush)               state_nx = IDLE;
            else if (dm_ack || tmo)  state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         req_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         fault_q    <= 1'b0;
         rd_data    <= '0;
         dm_we      <= 1'b0;
         dm_addr    <= '0;
         dm_be      <= '0;
         dm_wdata   <= '0;
         off_q      <= '0;
         width_q    <= '0;
         signed_q   <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_nx;
         rd_valid_q <= 1'b0;
         fault_q    <= 1'b0;
         if (accept) begin
            dm_addr  <= {op_addr[N-1:MAXW], MAXW'(0)};
            dm_we    <= op_write;
            dm_be    <= be_base << off;
            dm_wdata <= op_wdata << {off, 3'b000};
            off_q    <= off;
            width_q  <= op_width;
            signed_q <= op_signed;
            cnt      <= '0;
            req_q    <= 1'b1;
         end
         if (state == WAIT) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (state_nx != WAIT) req_q <= 1'b0;
            if (!flush && dm_ack) begin
               rd_valid_q <= ~dm_we;
               if (!dm_we) rd_data <= ext;
            end else if (!flush && tmo) begin
               fault_q <= 1'b1;
               rd_data <= '0;
            end
         end
      end
   end

`ifdef LSU_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      stall_cnt <= '0;
      else if (stall) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench for lsu_handshake (N=64, TIMEOUT=4) plus an N=32 copy.
// Stall cycles are counted at each rising edge.
module tb_lsu_handshake;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_read, op_write, op_signed, flush, dm_ack;
   logic [1:0]  op_width;
   logic [63:0] op_addr, op_wdata, dm_rdata;
   logic        stall, rd_valid, exc_misalign, exc_fault, dm_req, dm_we;
   logic [63:0] rd_data, dm_addr, dm_wdata;
   logic [7:0]  dm_be;

   logic        s_read, s_stall, s_rv, s_mis, s_flt, s_req, s_we;
   logic [1:0]  s_width;
   logic [31:0] s_addr, s_rd, s_daddr, s_wd;
   logic [3:0]  s_be;

`ifdef LSU_PERF_CNT_EN
   logic [31:0] stall_cnt, s_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int stall_seen = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (stall) stall_seen <= stall_seen + 1;

   lsu_handshake #(.N(64), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .op_read(op_read), .op_write(op_write), .op_signed(op_signed),
      .op_width(op_width), .op_addr(op_addr), .op_wdata(op_wdata),
      .flush(flush), .stall(stall), .rd_data(rd_data),
      .rd_valid(rd_valid), .exc_misalign(exc_misalign),
      .exc_fault(exc_fault), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack)
`ifdef LSU_PERF_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   lsu_handshake #(.N(32), .TIMEOUT(4)) dut32 (
      .clk(clk), .reset(reset),
      .op_read(s_read), .op_write(1'b0), .op_signed(1'b0),
      .op_width(s_width), .op_addr(s_addr), .op_wdata(32'd0),
      .flush(1'b0), .stall(s_stall), .rd_data(s_rd),
      .rd_valid(s_rv), .exc_misalign(s_mis),
      .exc_fault(s_flt), .dm_req(s_req), .dm_we(s_we),
      .dm_addr(s_daddr), .dm_be(s_be), .dm_wdata(s_wd),
      .dm_rdata(32'd0), .dm_ack(1'b0)
`ifdef LSU_PERF_CNT_EN
      , .stall_cnt(s_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic rd, input logic wr, input logic sg,
                        input logic [1:0] w, input logic [63:0] a,
                        input logic [63:0] wd);
      op_read = rd; op_write = wr; op_signed = sg;
      op_width = w; op_addr = a; op_wdata = wd;
   endtask

   task automatic idle_ops();
      issue(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
   endtask

   task automatic quick_load(input logic [63:0] a);
      @(negedge clk);
      issue(1'b1, 1'b0, 1'b0, 2'd3, a, 64'd0);
      @(negedge clk);
      dm_ack = 1'b1; dm_rdata = 64'h1234;
      @(negedge clk);
      dm_ack = 1'b0; idle_ops();
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
      s_read = 1'b0; s_width = 2'd0; s_addr = '0;
      idle_ops();
      #1;
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_req", 64'(dm_req), 64'd0);
      check("rst_rdata", rd_data, 64'd0);
      check("rst_be", 64'(dm_be), 64'd0);
      check("rst_fault", 64'(exc_fault), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // signed byte load, ack on first WAIT cycle
      @(negedge clk);
      issue(1'b1, 1'b0, 1'b1, 2'd0, 64'h1003, 64'd0);
      stall_seen = 0;
      #1;
      check("b_acc_stall", 64'(stall), 64'd1);
      check("b_acc_req", 64'(dm_req), 64'd0);
      @(negedge clk);
      check("b_req", 64'(dm_req), 64'd1);
      check("b_be", 64'(dm_be), 64'h08);
      check("b_addr", dm_addr, 64'h1000);
      check("b_we", 64'(dm_we), 64'd0);
      check("b_wait_stall", 64'(stall), 64'd1);
      dm_ack = 1'b1; dm_rdata = 64'h0000_0000_8000_0000;
      @(negedge clk);
      dm_ack = 1'b0;
      #1;
      check("b_rvalid", 64'(rd_valid), 64'd1);
      check("b_rdata", rd_data, 64'hFFFF_FFFF_FFFF_FF80);
      check("b_done_stall", 64'(stall), 64'd0);
      check("b_done_req", 64'(dm_req), 64'd0);
      check("b_stalls", 64'(stall_seen), 64'd2);
      @(negedge clk);
      idle_ops();
      #1;
      check("b_no_reacc", 64'(dm_req), 64'd0);
      check("b_rv_pulse", 64'(rd_valid), 64'd0);
      check("b_hold", rd_data, 64'hFFFF_FFFF_FFFF_FF80);

      // half store, ack on fourth WAIT cycle
      @(negedge clk);
      issue(1'b0, 1'b1, 1'b0, 2'd1, 64'h2006, 64'hBEEF);
      stall_seen = 0;
      @(negedge clk);
      check("h_be", 64'(dm_be), 64'hC0);
      check("h_wdata", dm_wdata, 64'hBEEF_0000_0000_0000);
      check("h_we", 64'(dm_we), 64'd1);
      check("h_addr", dm_addr, 64'h2000);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("h_wait_req", 64'(dm_req), 64'd1);
      end
      @(negedge clk);
      dm_ack = 1'b1;
      @(negedge clk);
      dm_ack = 1'b0;
      idle_ops();
      #1;
      check("h_rvalid", 64'(rd_valid), 64'd0);
      check("h_stall", 64'(stall), 64'd0);
      check("h_stalls", 64'(stall_seen), 64'd5);
      check("h_rd_keep", rd_data, 64'hFFFF_FFFF_FFFF_FF80);

      // misaligned word load
      @(negedge clk);
      issue(1'b1, 1'b0, 1'b0, 2'd2, 64'h3002, 64'd0);
      s_read = 1'b1; s_width = 2'd3; s_addr = 32'h0;
      #1;
      check("m_exc", 64'(exc_misalign), 64'd1);
      check("m_stall", 64'(stall), 64'd0);
      check("m32_exc", 64'(s_mis), 64'd1);
      check("m32_stall", 64'(s_stall), 64'd0);
      s_width = 2'd2; s_addr = 32'h4;
      #1;
      check("m32_ok", 64'(s_mis), 64'd0);
      s_read = 1'b0;
      @(negedge clk);
      check("m_req", 64'(dm_req), 64'd0);
      idle_ops();

      // timeout after 4 WAIT cycles
      @(negedge clk);
      issue(1'b1, 1'b0, 1'b0, 2'd3, 64'h40, 64'd0);
      stall_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t_req", 64'(dm_req), 64'd1);
      end
      @(negedge clk);
      idle_ops();
      #1;
      check("t_fault", 64'(exc_fault), 64'd1);
      check("t_req_done", 64'(dm_req), 64'd0);
      check("t_rdata", rd_data, 64'd0);
      check("t_rvalid", 64'(rd_valid), 64'd0);
      check("t_stalls", 64'(stall_seen), 64'd5);
      @(negedge clk);
      check("t_pulse", 64'(exc_fault), 64'd0);

      // flush together with ack in WAIT
      @(negedge clk);
      issue(1'b1, 1'b0, 1'b0, 2'd3, 64'h48, 64'd0);
      @(negedge clk);
      flush = 1'b1; dm_ack = 1'b1; dm_rdata = 64'h5555;
      #1;
      check("f_req", 64'(dm_req), 64'd0);
      @(negedge clk);
      flush = 1'b0; dm_ack = 1'b0; idle_ops();
      #1;
      check("f_rvalid", 64'(rd_valid), 64'd0);
      check("f_fault", 64'(exc_fault), 64'd0);
      check("f_stall", 64'(stall), 64'd0);
      check("f_rdata", rd_data, 64'd0);
      @(negedge clk);
      check("f_idle", 64'(dm_req), 64'd0);

      // reset during WAIT
      @(negedge clk);
      issue(1'b1, 1'b0, 1'b0, 2'd3, 64'h50, 64'd0);
      @(negedge clk);
      check("r_req", 64'(dm_req), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("r_async", 64'(dm_req), 64'd0);
      idle_ops();
      @(negedge clk);
      reset = 1'b0;

`ifdef LSU_PERF_CNT_EN
      quick_load(64'h60);
      quick_load(64'h68);
      quick_load(64'h70);
      @(negedge clk);
      check("p_cnt", 64'(stall_cnt), 64'd6);
      force dut.stall_cnt = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.stall_cnt;
      issue(1'b1, 1'b0, 1'b0, 2'd3, 64'h78, 64'd0);
      @(posedge clk);
      #1;
      idle_ops();
      check("p_wrap", 64'(stall_cnt), 64'd0);
      @(negedge clk);
      dm_ack = 1'b1;
      @(negedge clk);
      dm_ack = 1'b0;
`endif

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
